// File: rtl/inst_ram_loader.sv
// inst_ram_loader: run-time loadable instruction RAM.
// Four UART bytes are packed into each instruction word, and the words are
// written from address 0 upward. Fetches use a valid/ready handshake and come
// back after a pipelined read of 1 or 2 cycles. No fetch is accepted while a
// program is loading. DEPTH_LOG2 must be 29 or less.
module inst_ram_loader #(
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned BIG_ENDIAN   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [DEPTH_LOG2:0]   load_len,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  loading,
  output logic                  load_done,
  input  logic                  fetch_ce,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_ready,
  output logic                  inst_valid,
  output logic [31:0]           inst,
  output logic                  inst_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [DEPTH_LOG2:0] r_ptr, w_ptr_nxt;
  logic [DEPTH_LOG2:0] r_len, w_len_nxt;
  logic [1:0]          r_bcnt, w_bcnt_nxt;
  logic [31:0]         r_asm, w_asm_nxt;
  logic                r_done, w_done_nxt;
  logic                w_we;
  logic [31:0]         w_word;
  logic [1:0]          w_slot;
  logic [DEPTH_LOG2:0] w_eff_len;
  logic [DEPTH_LOG2:0] w_ptr_inc;

  logic [31:0] r_mem [DEPTH];

  logic                  w_acc, w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  r_v1, r_e1;
  logic [31:0]           r_rdata;
  logic [31:0]           w_s1_data;

  assign w_eff_len = (load_len > DEPTH_W) ? DEPTH_W : load_len;
  assign w_ptr_inc = r_ptr + 1'b1;
  assign w_slot    = (BIG_ENDIAN != 0) ? ~r_bcnt : r_bcnt;

  // Merge the incoming byte into its lane of the word being assembled.
  always_comb begin
    w_word = r_asm;
    case (w_slot)
      2'd0:    w_word[7:0]   = rx_data;
      2'd1:    w_word[15:8]  = rx_data;
      2'd2:    w_word[23:16] = rx_data;
      default: w_word[31:24] = rx_data;
    endcase
  end

  // State, pointer, byte-count and assembly registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_len   <= '0;
      r_bcnt  <= '0;
      r_asm   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_len   <= w_len_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_asm   <= w_asm_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: load_start takes priority over byte acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_len_nxt   = r_len;
    w_bcnt_nxt  = r_bcnt;
    w_asm_nxt   = r_asm;
    w_done_nxt  = 1'b0;
    w_we        = 1'b0;
    if (load_start) begin
      w_len_nxt  = w_eff_len;
      w_ptr_nxt  = '0;
      w_bcnt_nxt = '0;
      w_asm_nxt  = '0;
      if (w_eff_len == '0) begin
        w_state_nxt = S_RUN;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_LOAD;
      end
    end else if (r_state == S_LOAD && rx_valid) begin
      if (r_bcnt == 2'd3) begin
        w_we       = 1'b1;
        w_ptr_nxt  = w_ptr_inc;
        w_bcnt_nxt = '0;
        w_asm_nxt  = '0;
        if (w_ptr_inc == r_len) begin
          w_state_nxt = S_RUN;
          w_done_nxt  = 1'b1;
        end
      end else begin
        w_asm_nxt  = w_word;
        w_bcnt_nxt = r_bcnt + 2'd1;
      end
    end
  end

  assign rx_ready    = (r_state == S_LOAD);
  assign loading     = (r_state == S_LOAD);
  assign load_done   = r_done;
  assign fetch_ready = (r_state == S_RUN) & ~load_start;

  // Loader write port; the word includes the byte arriving this cycle.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_ptr[DEPTH_LOG2-1:0]] <= w_word;
  end

  assign w_acc = fetch_ce & fetch_req & fetch_ready;
  assign w_err = (|fetch_addr[1:0]) | (|fetch_addr[31:DEPTH_LOG2+2]);
  assign w_idx = fetch_addr[DEPTH_LOG2+1:2];

  // First response stage; load_start already blocks w_acc, which also squashes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
    end else begin
      r_v1 <= w_acc;
      r_e1 <= w_acc & w_err;
    end
  end

  // Unreset read register, so the array can map onto block RAM; erroring fetches skip the read.
  always_ff @(posedge clk) begin
    if (w_acc & ~w_err) r_rdata <= r_mem[w_idx];
  end

  assign w_s1_data = (r_v1 & ~r_e1) ? r_rdata : '0;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic        r_v2, r_e2;
      logic [31:0] r_d2;
      // Second response stage, cleared by a load_start that lands mid-flight.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_v2 <= 1'b0;
          r_e2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1 & ~load_start;
          r_e2 <= r_e1;
          r_d2 <= w_s1_data;
        end
      end
      assign inst_valid = r_v2;
      assign inst_err   = r_v2 & r_e2;
      assign inst       = r_v2 ? r_d2 : '0;
    end else begin : g_lat1
      assign inst_valid = r_v1;
      assign inst_err   = r_v1 & r_e1;
      assign inst       = w_s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_inst_ram_loader.sv
// Bench for inst_ram_loader. Two instances are driven by the same stimulus:
// one is little-endian with a 1-cycle read, the other big-endian with a
// 2-cycle read. A behavioural model predicts each response and pushes it
// into a per-instance queue. Monitors pop the queues at the falling edge.
module tb_inst_ram_loader;

  localparam int D     = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [D:0]  load_len;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        fetch_ce, fetch_req;
  logic [31:0] fetch_addr;

  logic        le_rx_ready, le_loading, le_load_done, le_fetch_ready, le_valid, le_err;
  logic [31:0] le_inst;
  logic        be_rx_ready, be_loading, be_load_done, be_fetch_ready, be_valid, be_err;
  logic [31:0] be_inst;

  inst_ram_loader #(.DEPTH_LOG2(D), .READ_LATENCY(1), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(le_rx_ready),
    .loading(le_loading), .load_done(le_load_done), .fetch_ce(fetch_ce),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(le_fetch_ready),
    .inst_valid(le_valid), .inst(le_inst), .inst_err(le_err));

  inst_ram_loader #(.DEPTH_LOG2(D), .READ_LATENCY(2), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(be_rx_ready),
    .loading(be_loading), .load_done(be_load_done), .fetch_ce(fetch_ce),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(be_fetch_ready),
    .inst_valid(be_valid), .inst(be_inst), .inst_err(be_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q_le[$];
  exp_t q_be[$];
  exp_t e_le, e_be;

  // Reference model: mode 0 = no program, 1 = loading, 2 = running.
  int          mode_now  = 0;
  int          mode_next = 0;
  bit          done_now  = 1'b0;
  bit          done_next = 1'b0;
  int          m_ptr, m_len;
  logic [7:0]  m_bytes[$];
  logic [31:0] ref_le[DEPTH];
  logic [31:0] ref_be[DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // One stimulus cycle: drive the inputs, then advance the model.
  task automatic drive(input bit ls, input int len, input bit rv, input logic [7:0] rd,
                       input bit ce, input bit req, input logic [31:0] addr);
    logic [31:0] wle, wbe;
    logic        err;
    @(posedge clk);
    #1;
    mode_now   = mode_next;
    done_now   = done_next;
    done_next  = 1'b0;
    load_start = ls;
    load_len   = len[D:0];
    rx_valid   = rv;
    rx_data    = rd;
    fetch_ce   = ce;
    fetch_req  = req;
    fetch_addr = addr;
    if (ls) begin
      while (q_le.size() > 0 && q_le[$].due > cyc) void'(q_le.pop_back());
      while (q_be.size() > 0 && q_be[$].due > cyc) void'(q_be.pop_back());
      m_ptr = 0;
      m_bytes.delete();
      m_len = (len > DEPTH) ? DEPTH : len;
      if (m_len == 0) begin
        mode_next = 2;
        done_next = 1'b1;
      end else begin
        mode_next = 1;
      end
    end else if (mode_now == 1 && rv) begin
      m_bytes.push_back(rd);
      if (m_bytes.size() == 4) begin
        wle = '0;
        wbe = '0;
        for (int k = 0; k < 4; k++) begin
          wle = wle | (32'(m_bytes[k]) << (8 * k));
          wbe = wbe | (32'(m_bytes[k]) << (8 * (3 - k)));
        end
        ref_le[m_ptr] = wle;
        ref_be[m_ptr] = wbe;
        m_bytes.delete();
        m_ptr++;
        if (m_ptr == m_len) begin
          mode_next = 2;
          done_next = 1'b1;
        end
      end
    end else if (mode_now == 2 && ce && req) begin
      err = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
      q_le.push_back('{data: err ? 32'h0 : ref_le[addr[5:2]], err: err, due: cyc + 1});
      q_be.push_back('{data: err ? 32'h0 : ref_be[addr[5:2]], err: err, due: cyc + 2});
    end
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] addr);
    drive(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1, addr);
  endtask

  task automatic start_load(input int len);
    drive(1'b1, len, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
  endtask

  // Sends one byte, sometimes after a stall; stall cycles also attempt a fetch.
  task automatic send_byte(input logic [7:0] b);
    while ($urandom_range(0, 2) == 0)
      drive(1'b0, 0, 1'b0, 8'($urandom), 1'b1, 1'b1, 32'h0);
    drive(1'b0, 0, 1'b1, b, 1'b0, 1'b0, 32'h0);
  endtask

  // Control outputs and both response streams, checked at the falling edge.
  always @(negedge clk) begin
    chk("le_loading", {31'h0, le_loading}, {31'h0, mode_now == 1});
    chk("be_loading", {31'h0, be_loading}, {31'h0, mode_now == 1});
    chk("le_rx_ready", {31'h0, le_rx_ready}, {31'h0, mode_now == 1});
    chk("be_rx_ready", {31'h0, be_rx_ready}, {31'h0, mode_now == 1});
    chk("le_fetch_ready", {31'h0, le_fetch_ready}, {31'h0, mode_now == 2 && !load_start});
    chk("be_fetch_ready", {31'h0, be_fetch_ready}, {31'h0, mode_now == 2 && !load_start});
    chk("le_load_done", {31'h0, le_load_done}, {31'h0, done_now});
    chk("be_load_done", {31'h0, be_load_done}, {31'h0, done_now});

    while (q_le.size() > 0 && q_le[0].due < cyc) begin
      void'(q_le.pop_front());
      fail_now("le_missing_response");
    end
    if (le_valid) begin
      if (q_le.size() == 0) fail_now("le_unexpected_response");
      else begin
        e_le = q_le.pop_front();
        chk("le_due", cyc, e_le.due);
        chk("le_inst", le_inst, e_le.data);
        chk("le_err", {31'h0, le_err}, {31'h0, e_le.err});
      end
    end else begin
      chk("le_idle_inst", le_inst, 32'h0);
      chk("le_idle_err", {31'h0, le_err}, 32'h0);
    end

    while (q_be.size() > 0 && q_be[0].due < cyc) begin
      void'(q_be.pop_front());
      fail_now("be_missing_response");
    end
    if (be_valid) begin
      if (q_be.size() == 0) fail_now("be_unexpected_response");
      else begin
        e_be = q_be.pop_front();
        chk("be_due", cyc, e_be.due);
        chk("be_inst", be_inst, e_be.data);
        chk("be_err", {31'h0, be_err}, {31'h0, e_be.err});
      end
    end else begin
      chk("be_idle_inst", be_inst, 32'h0);
      chk("be_idle_err", {31'h0, be_err}, 32'h0);
    end
  end

  initial begin
    rst        = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    rx_valid   = 1'b0;
    rx_data    = '0;
    fetch_ce   = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Fetch attempts while no program is loaded.
    repeat (3) fetch(32'h0);

    // Fill the whole memory with random words.
    start_load(DEPTH);
    repeat (DEPTH * 4) send_byte(8'($urandom));
    idle();
    for (int i = 0; i < DEPTH; i++) fetch(32'(i * 4));

    // Two-word program with known byte values.
    start_load(2);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
    idle();
    fetch(32'h0);
    fetch(32'h4);
    idle();
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    repeat (3) idle();

    // Misaligned and out-of-range addresses, and a fetch with the chip disabled.
    fetch(32'h2);
    fetch(32'(DEPTH * 4));
    fetch(32'h8000_0000);
    fetch(32'h3F);
    drive(1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h4);
    repeat (3) idle();

    // A restart in the middle of a word discards that partial word.
    start_load(3);
    repeat (5) send_byte(8'($urandom));
    start_load(1);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    idle();
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    repeat (3) idle();

    // A load_start while a fetch is in flight, including a zero-length load.
    fetch(32'h8);
    start_load(0);
    fetch(32'h4);
    drive(1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0);
    fetch(32'hC);
    repeat (3) idle();

    // A length above the depth is clamped to the depth.
    start_load(31);
    repeat (DEPTH * 4) send_byte(8'($urandom));
    repeat (2) idle();

    // Random mix of loads, aborted loads and fetch bursts.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        int len;
        int nb;
        len = $urandom_range(0, 4);
        nb  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : len * 4;
        start_load(len);
        for (int b = 0; b < nb; b++) send_byte(8'($urandom));
        if (nb != len * 4) begin
          start_load(1);
          repeat (4) send_byte(8'($urandom));
        end
      end else begin
        int n;
        n = $urandom_range(1, 6);
        for (int f = 0; f < n; f++) begin
          if ($urandom_range(0, 7) == 0) fetch($urandom);
          else fetch(32'($urandom_range(0, DEPTH - 1) * 4));
        end
        if ($urandom_range(0, 1) == 0) idle();
      end
    end

    repeat (5) idle();
    chk("le_queue_drained", 32'(q_le.size()), 32'h0);
    chk("be_queue_drained", 32'(q_be.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_ram_loader.md
Name: inst_ram_loader

Overview:
Parametrised instruction memory for the RISC-V core. It replaces the fixed, file-initialised instruction ROM with a RAM that is loaded at run time from the UART receive byte stream, where each group of 4 bytes is assembled into one instruction word. It serves instruction fetches through a valid/ready handshake with a configurable pipelined read latency. Fetch is blocked while a load is in progress.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (depth = 2^DEPTH_LOG2)
READ_LATENCY, 1, fetch-accept to inst_valid latency in cycles; legal values 1 or 2
BIG_ENDIAN, 0, byte order: 0 = first received byte goes to inst[7:0]; 1 = first received byte goes to inst[31:24]

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
load_start  input  1  one-cycle pulse that begins a new program load
load_len  input  DEPTH_LOG2+1  number of words to load; sampled on load_start
rx_data  input  8  incoming byte from the UART receiver
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader accepts a byte this cycle
loading  output  1  high while in the LOAD state
load_done  output  1  one-cycle pulse when a load completes
fetch_ce  input  1  fetch chip enable
fetch_req  input  1  fetch request
fetch_addr  input  32  byte address of the requested instruction
fetch_ready  output  1  a fetch can be accepted this cycle
inst_valid  output  1  inst carries a fetch response
inst  output  32  fetched instruction word; 0 whenever inst_valid=0
inst_err  output  1  response is for a misaligned or out-of-range address; qualified by inst_valid

Behaviour:
- States: IDLE (no program loaded), LOAD, RUN.
- Reset: state=IDLE; word pointer, byte count and assembly register cleared; all outputs 0. Memory contents are not reset.
- Reset asserted mid-load or mid-fetch: takes effect immediately. The load is abandoned and all in-flight responses are dropped.
- load_start accepted in any state:
  - Enters LOAD next cycle; word pointer=0, byte count=0.
  - Effective length = min(load_len, 2^DEPTH_LOG2).
  - Effective length 0: skip LOAD, go to RUN next cycle, pulse load_done in that same cycle.
- LOAD state:
  - rx_ready=1 and loading=1.
  - A byte is accepted when rx_valid & rx_ready.
  - Byte k (k=0..3) of the current word is placed per BIG_ENDIAN.
  - On acceptance of byte 3, the completed word (including this byte) is written at the word pointer on that edge; the pointer then increments and the byte count wraps to 0.
  - When the pointer reaches the effective length: state=RUN next cycle and load_done pulses for exactly 1 cycle as RUN is entered.
  - A partial word is never written.
- Outside LOAD: rx_ready=0 and bytes are ignored.
- load_start during LOAD: restarts the load. The partial word is discarded and words already written are kept.
- fetch_ready = (state==RUN) & ~load_start. It is 0 in IDLE and LOAD.
- Fetch acceptance:
  - A fetch is accepted when fetch_ce & fetch_req & fetch_ready.
  - fetch_ce=0 means no request, regardless of fetch_req.
- Fetch response pipeline:
  - inst_valid is asserted exactly READ_LATENCY cycles after the accepting edge.
  - Fully pipelined: one accept per cycle gives one response per cycle, in order.
  - The word read uses index fetch_addr[DEPTH_LOG2+1:2].
  - If fetch_addr[1:0]!=0, or any bit of fetch_addr[31:DEPTH_LOG2+2] is set: inst=0 and inst_err=1 with inst_valid=1, and memory is not read.
- Word reads return the word stored by the loader; no byte reordering is applied at read time.
- load_start with fetches in flight: every pending response is squashed (inst_valid stays 0). A load_start in the same cycle as fetch_req means the fetch is not accepted.
- Write/read collision cannot occur because fetch is blocked during LOAD.

Test Plan:
1. Reset then fetch attempt: rst low for 3 cycles, then fetch_req=1 in IDLE -> fetch_ready=0, inst_valid=0 and inst=0 throughout.
2. Little-endian load, BIG_ENDIAN=0:
   - Stimulus: load_start with load_len=2, bytes 0x13,0x05,0x10,0x00,0x93,0x05,0x20,0x00.
   - Required: load_done pulses once after byte 8.
   - Fetch addr 0x0 -> inst=0x00100513. Fetch addr 0x4 -> inst=0x00200593.
3. Big-endian variant: same stimulus as scenario 2 with BIG_ENDIAN=1 -> fetch addr 0x0 returns inst=0x13051000.
4. Latency and throughput, READ_LATENCY=2:
   - Stimulus: back-to-back fetches to 0x0, 0x4, 0x8 on consecutive cycles.
   - Required: inst_valid high for 3 consecutive cycles starting 2 cycles after the first accept, with responses in order.
5. Error responses: fetch addr 0x2 -> inst_valid=1, inst_err=1, inst=0. Fetch addr (2^DEPTH_LOG2)*4 -> inst_err=1.
6. Abort and restart:
   - load_start, 5 bytes, load_start again with load_len=1, then 4 bytes: 1 word written from the new bytes, load_done pulses once.
   - rx_valid stalls (rx_valid=0 gaps) do not corrupt assembly.
   - load_start issued with a fetch in flight -> that response is suppressed.
